// File: rtl/rr_arb_pkg.sv
// Shared types and default sizing for the round-robin arbiter.
package rr_arb_pkg;

  localparam int unsigned RR_N_DEFAULT        = 4;
  localparam int unsigned RR_MAX_HOLD_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit at or after ptr, wrapping.
module rr_pick
  import rr_arb_pkg::*;
#(
  parameter int unsigned N  = RR_N_DEFAULT,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx
);

  int unsigned cand;

  // Scan offsets 0..N-1 from ptr; the first hit wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = 0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = 32'(ptr) + i;
      if (cand >= N) begin
        cand = cand - N;
      end
      if (!found && req[cand[IW-1:0]]) begin
        found = 1'b1;
        idx   = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/rr_arbiter_fsm.sv
// Round-robin arbiter with bounded tenure and a dead cycle between owners.
module rr_arbiter_fsm
  import rr_arb_pkg::*;
#(
  parameter int unsigned N        = RR_N_DEFAULT,
  parameter int unsigned MAX_HOLD = RR_MAX_HOLD_DEFAULT
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [N-1:0]                           req,
  input  logic                                   done,
  output logic [N-1:0]                           gnt,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0]   gnt_id,
  output logic                                   busy,
  output logic                                   timeout
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned HW = $clog2(MAX_HOLD);

  arb_state_t    state;
  logic [IW-1:0] owner;
  logic [IW-1:0] ptr;
  logic [HW-1:0] hold;

  logic          pick_found;
  logic [IW-1:0] pick_idx;
  logic          expired_c;
  logic          normal_exit_c;
  logic [IW-1:0] ptr_next_c;

  rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .req   (req),
    .ptr   (ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign expired_c     = (hold == HW'(MAX_HOLD - 1));
  assign normal_exit_c = done || !req[owner];
  assign ptr_next_c    = (owner == IW'(N - 1)) ? '0 : owner + IW'(1);

  // State, owner, pointer, hold counter and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      owner   <= '0;
      ptr     <= '0;
      hold    <= '0;
      gnt     <= '0;
      gnt_id  <= '0;
      busy    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE, RELEASE: begin
          hold <= '0;
          if (pick_found) begin
            state  <= GRANT;
            owner  <= pick_idx;
            gnt    <= N'(1) << pick_idx;
            gnt_id <= pick_idx;
            busy   <= 1'b1;
          end else begin
            state  <= IDLE;
            gnt    <= '0;
            gnt_id <= '0;
            busy   <= 1'b0;
          end
        end
        GRANT: begin
          if (normal_exit_c || expired_c) begin
            state   <= RELEASE;
            ptr     <= ptr_next_c;
            hold    <= '0;
            gnt     <= '0;
            gnt_id  <= '0;
            busy    <= 1'b0;
            // A coincident done or request drop outranks expiry.
            timeout <= !normal_exit_c;
          end else begin
            hold <= hold + HW'(1);
          end
        end
        default: begin
          state  <= IDLE;
          owner  <= '0;
          hold   <= '0;
          gnt    <= '0;
          gnt_id <= '0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter_fsm.sv
// Directed vector bench for rr_arbiter_fsm (N=4, MAX_HOLD=8).
module tb_rr_arbiter_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       timeout;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] id;
    logic       busy;
    logic       to;
  } vec_t;

  vec_t vecs[$];

  rr_arbiter_fsm #(.N(4), .MAX_HOLD(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", name, got, exp);
    else passed++;
  endtask

  task automatic check_out(input string tag, input logic [3:0] eg, input logic [1:0] ei,
                           input logic eb, input logic et);
    check({tag, " gnt"}, 32'(gnt), 32'(eg));
    check({tag, " gnt_id"}, 32'(gnt_id), 32'(ei));
    check({tag, " busy"}, 32'(busy), 32'(eb));
    check({tag, " timeout"}, 32'(timeout), 32'(et));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = '0;
    done  = 1'b0;
    #2;
    check_out("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    #10;
    rst_n = 1'b1;

    // Rotation under full request, owner drop, idle-time done ignored.
    vecs.push_back('{4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0});
    vecs.push_back('{4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0});
    vecs.push_back('{4'b1111, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0});
    vecs.push_back('{4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0});
    vecs.push_back('{4'b1111, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0});
    vecs.push_back('{4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0});
    vecs.push_back('{4'b1111, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0});
    vecs.push_back('{4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0});
    vecs.push_back('{4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0});
    vecs.push_back('{4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0});
    vecs.push_back('{4'b0011, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0});
    vecs.push_back('{4'b0011, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0});
    vecs.push_back('{4'b0001, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0});
    vecs.push_back('{4'b0011, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0});
    vecs.push_back('{4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0});
    vecs.push_back('{4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0});
    vecs.push_back('{4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0});
    vecs.push_back('{4'b0100, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0});
    vecs.push_back('{4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0});

    for (int i = 0; i < vecs.size(); i++) begin
      req  = vecs[i].req;
      done = vecs[i].done;
      tick();
      check_out($sformatf("row%0d", i), vecs[i].gnt, vecs[i].id, vecs[i].busy, vecs[i].to);
    end

    // Hold expiry: eight grant cycles, then a timeout dead cycle, then re-grant.
    req  = 4'b0001;
    done = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      check_out($sformatf("expiry c%0d", c), 4'b0001, 2'd0, 1'b1, 1'b0);
    end
    tick();
    check_out("expiry release", 4'b0000, 2'd0, 1'b0, 1'b1);
    tick();
    check_out("expiry regrant", 4'b0001, 2'd0, 1'b1, 1'b0);

    // done on the eighth grant cycle is a normal release.
    for (int c = 2; c <= 8; c++) begin
      tick();
      check($sformatf("simul c%0d gnt", c), 32'(gnt), 32'(4'b0001));
    end
    done = 1'b1;
    tick();
    check_out("simul release", 4'b0000, 2'd0, 1'b0, 1'b0);
    done = 1'b0;
    req  = 4'b0000;
    tick();
    check_out("simul idle", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Reset in cycle 3 of a tenure drops the grant without an edge.
    req = 4'b1001;
    tick();
    check_out("pre-reset c1", 4'b1000, 2'd3, 1'b1, 1'b0);
    tick();
    tick();
    check_out("pre-reset c3", 4'b1000, 2'd3, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_out("async reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_out("post-reset grant", 4'b0001, 2'd0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
